featuremap_conv2d_multich: RTL and testbench
============================================

Name: featuremap_conv2d_multich

Overview:
Generalised 3x3 feature-map convolution filter. It streams a zero-padded raster image of CHANNELS interleaved channels from an upstream FIFO. It produces one output feature map: the convolution summed across channels, plus bias, with optional ReLU. Weights and bias are loaded at run time over a serial config port, so one instance serves every filter of a layer. It sits between the padded-input FIFO and the next layer's FIFO/pooling stage.

Parameters:
DATA_WIDTH, 16, signed two's-complement fixed-point word width of pixels, weights, bias and output
FRAC_BITS, 8, fractional bits of the fixed-point format
CHANNELS, 3, number of input channels, 1..16
WIDTH, 112, output feature-map width; the padded input row is WIDTH+2
HEIGHT, 112, output feature-map height; the padded input has HEIGHT+2 rows
RELU_EN, 1, 1 = clamp negative results to 0

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
data_in  in  DATA_WIDTH*CHANNELS  one padded pixel of all channels; channel 0 occupies the MSBs
data_fifo_empty  in  1  upstream FIFO empty
rdreq  out  1  pop request to upstream FIFO; a pixel is consumed in any cycle where rdreq=1
cfg_load  in  1  single-cycle request to enter weight load
w_wr  in  1  weight word strobe
w_data  in  DATA_WIDTH  weight/bias word
cfg_busy  out  1  high while in LOAD
valid_out  out  1  data_out valid, single cycle per pixel
data_out  out  DATA_WIDTH  output pixel
frame_done  out  1  pulses together with the last output pixel of a frame

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: state=LOAD, all counters 0, pipeline valid bits 0. Outputs: rdreq=0, valid_out=0, data_out=0, frame_done=0, cfg_busy=1. Weight registers keep their contents but are treated as invalid.
- FSM states: LOAD, RUN.
- LOAD behaviour:
  - Each w_wr writes w_data to word index widx, which then increments.
  - Load order: ch0 k0..k8, ch1 k0..k8, ..., then bias. Total CHANNELS*9+1 words.
  - After the bias word, the state goes to RUN on the next cycle, with widx and the row/col counters cleared.
  - rdreq=0 throughout LOAD.
- cfg_load handling:
  - Honoured in RUN only when row=col=0 and the output pipeline is empty. In that case the state goes to LOAD and widx=0.
  - Otherwise ignored; no latching.
  - In LOAD, cfg_load restarts widx at 0.
- RUN behaviour:
  - rdreq = ~data_fifo_empty, combinational.
  - Each consumed pixel advances col 0..WIDTH+1. On wrap, row advances 0..HEIGHT+1. On the row wrap the frame ends and the counters return to 0; weights are retained.
  - Empty-FIFO cycles stall the counters and line buffers with no state change.
- Line buffers: per channel, 2 rows of WIDTH+2 words. The window holds the last 3 rows × 3 cols. Tap k0 = oldest row, leftmost column; k8 = current pixel.
- Window validity: the window is valid when the consumed pixel has row>=2 and col>=2. This gives exactly WIDTH*HEIGHT outputs per frame.
- Arithmetic:
  - Products are full precision (2*DATA_WIDTH bits).
  - The accumulator is 2*DATA_WIDTH+ceil(log2(9*CHANNELS+1)) bits.
  - Sum all 9*CHANNELS products, then add (bias <<< FRAC_BITS).
  - Arithmetic-shift right by FRAC_BITS, truncating toward −∞.
  - Saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Then, if RELU_EN, negative results become 0.
- Latency: fixed 3 cycles from the consuming cycle to valid_out (stage 1 multiply, stage 2 sum tree, stage 3 bias/shift/sat/ReLU). The pipeline advances every cycle regardless of FIFO stalls. Back-to-back outputs are allowed.
- frame_done: high in the cycle valid_out carries the output for row=HEIGHT+1, col=WIDTH+1.
- No output backpressure: the downstream stage must accept one word per cycle.
- Reset mid-frame: discards partial frame and in-flight outputs; valid_out=0 next cycle; weights must be reloaded.
- w_wr while in RUN: ignored.

Test Plan:
- Setup for all scenarios: CHANNELS=2, WIDTH=4, HEIGHT=4, DATA_WIDTH=16, FRAC_BITS=8.
- Load ch0 centre tap k4=0x0100, all other weights 0, bias 0. Stream a padded 6x6 frame with ch0 interior = 1..16 (×0x0100), ch1 = 0. -> 16 outputs equal to the input interior in raster order. frame_done is set with the 16th output. Each output appears 3 cycles after its consuming cycle.
- Set all 18 weights = 0x0100 and bias = 0x0200; all pixels of both channels = 0x0100, padding 0. -> Corner output = (4+4)+2 = 0x0A00; edge output 0x0E00; centre output 0x1400.
- Saturation and ReLU: weights 0x7FFF, pixels 0x7FFF -> output 0x7FFF. Negate ch0 weights and zero ch1, RELU_EN=1 -> output 0x0000. With RELU_EN=0 -> output 0x8000.
- Randomly toggle data_fifo_empty ~50% during a frame -> outputs bit-identical to the unstalled run, and the count is exactly 16.
- Pulse cfg_load mid-frame -> ignored. Pulse cfg_load at a frame boundary -> cfg_busy=1; reload different weights; the second frame matches the new weights.
- Assert rst during row 3 -> valid_out=0 next cycle, cfg_busy=1; after reload, a fresh frame produces a correct 16-pixel output.

Source files
------------

// File: rtl/featuremap_conv2d_multich.sv
// featuremap_conv2d_multich: streaming 3x3 multi-channel convolution over a zero-padded
// raster, weights/bias loaded serially at run time, 3-stage multiply / sum / requantise pipe.
module featuremap_conv2d_multich #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned WIDTH      = 112,
    parameter int unsigned HEIGHT     = 112,
    parameter bit          RELU_EN    = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH*CHANNELS-1:0] data_in,
    input  logic                           data_fifo_empty,
    output logic                           rdreq,
    input  logic                           cfg_load,
    input  logic                           w_wr,
    input  logic [DATA_WIDTH-1:0]          w_data,
    output logic                           cfg_busy,
    output logic                           valid_out,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           frame_done
);
    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned NTAP  = 9 * CHANNELS;
    localparam int unsigned NW    = NTAP + 1;
    localparam int unsigned ACC_W = PW + $clog2(NTAP + 1);
    localparam int unsigned PCOLS = WIDTH + 2;
    localparam int unsigned PROWS = HEIGHT + 2;
    localparam int unsigned CW    = $clog2(PCOLS);
    localparam int unsigned RW    = $clog2(PROWS);
    localparam int unsigned IW    = $clog2(NW);

    typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           widx_q, widx_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [DW-1:0]           w_q [NW];
    logic [DW-1:0]           lb_q [CHANNELS][2][PCOLS];
    logic [DW-1:0]           wa_q [CHANNELS][3];
    logic [DW-1:0]           wb_q [CHANNELS][3];
    logic [DW-1:0]           pix [CHANNELS];
    logic signed [DW-1:0]    tap [NTAP];
    logic signed [PW-1:0]    prod_q [NTAP];
    logic signed [ACC_W-1:0] sum_d, sum_q;
    logic signed [ACC_W-1:0] bias_ext, biased, shifted;
    logic [DW-1:0]           res_c, data_q;
    logic                    s1_v_q, s1_last_q, s2_v_q, s2_last_q, valid_q, done_q;
    logic                    cfg_take, win_ok, last_px;

    function automatic logic signed [PW-1:0] mul(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
        logic signed [PW-1:0] ae, be;
        ae = {{DW{a[DW-1]}}, a};
        be = {{DW{b[DW-1]}}, b};
        return ae * be;
    endfunction

    // Reconfiguration is only safe between frames with nothing left in flight
    assign cfg_take = (state_q == ST_RUN) && cfg_load && (row_q == '0) && (col_q == '0)
                      && !s1_v_q && !s2_v_q && !valid_q;
    assign win_ok   = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign last_px  = (row_q == RW'(PROWS - 1)) && (col_q == CW'(PCOLS - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_LOAD;
        else     state_q <= state_d;
    end

    // FSM next state: leave LOAD after the bias word, re-enter LOAD on an accepted cfg_load
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: if (!cfg_load && w_wr && (widx_q == IW'(NW - 1))) state_d = ST_RUN;
            ST_RUN:  if (cfg_take) state_d = ST_LOAD;
            default: state_d = ST_LOAD;
        endcase
    end

    // FSM outputs; an accepted cfg_load withholds the pop so no pixel is lost
    always_comb begin
        cfg_busy = (state_q == ST_LOAD);
        rdreq    = (state_q == ST_RUN) && !data_fifo_empty && !cfg_take;
    end

    // Weight index and raster position counters
    always_comb begin
        widx_d = widx_q;
        col_d  = col_q;
        row_d  = row_q;
        if (state_q == ST_LOAD) begin
            col_d = '0;
            row_d = '0;
            if (cfg_load)  widx_d = '0;
            else if (w_wr) widx_d = (widx_q == IW'(NW - 1)) ? '0 : widx_q + IW'(1);
        end else if (cfg_take) begin
            widx_d = '0;
        end else if (rdreq) begin
            if (col_q == CW'(PCOLS - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(PROWS - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Control registers and pipeline valid/last flags
    always_ff @(posedge clk) begin
        if (rst) begin
            widx_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_last_q <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            widx_q    <= widx_d;
            col_q     <= col_d;
            row_q     <= row_d;
            s1_v_q    <= rdreq && win_ok;
            s1_last_q <= rdreq && last_px;
            s2_v_q    <= s1_v_q;
            s2_last_q <= s1_last_q;
            valid_q   <= s2_v_q;
            done_q    <= s2_last_q;
            if (s2_v_q) data_q <= res_c;
        end
    end

    // Weight/bias store; survives reset but is reloaded before use
    always_ff @(posedge clk) begin
        if ((state_q == ST_LOAD) && w_wr && !cfg_load) w_q[widx_q] <= w_data;
    end

    // Channel unpack (ch0 in MSBs) and 3x3 window taps; k8 is the pixel being consumed
    always_comb begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
            pix[c] = data_in[DW*(CHANNELS-c)-1 -: DW];
            for (int r = 0; r < 3; r++) begin
                tap[c*9 + r*3 + 0] = wb_q[c][r];
                tap[c*9 + r*3 + 1] = wa_q[c][r];
            end
            tap[c*9 + 2] = lb_q[c][1][col_q];
            tap[c*9 + 5] = lb_q[c][0][col_q];
            tap[c*9 + 8] = pix[c];
        end
    end

    // Line buffers and column shift registers advance only on a consumed pixel
    always_ff @(posedge clk) begin
        if (rdreq) begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                lb_q[c][1][col_q] <= lb_q[c][0][col_q];
                lb_q[c][0][col_q] <= pix[c];
                wb_q[c]           <= wa_q[c];
                wa_q[c][0]        <= lb_q[c][1][col_q];
                wa_q[c][1]        <= lb_q[c][0][col_q];
                wa_q[c][2]        <= pix[c];
            end
        end
    end

    // Stage 1 products and stage 2 sum; pipe runs every cycle, qualified by valid flags
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < int'(NTAP); i++) begin
            sum_d = sum_d + {{(ACC_W-PW){prod_q[i][PW-1]}}, prod_q[i]};
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NTAP); i++) prod_q[i] <= mul(tap[i], w_q[i]);
        sum_q <= sum_d;
    end

    // Stage 3: add aligned bias, floor-shift, saturate, optional ReLU
    always_comb begin
        bias_ext = {{(ACC_W-DW){w_q[NW-1][DW-1]}}, w_q[NW-1]};
        biased   = sum_q + (bias_ext <<< FRAC_BITS);
        shifted  = biased >>> FRAC_BITS;
        if (!shifted[ACC_W-1] && (|shifted[ACC_W-2:DW-1]))
            res_c = {1'b0, {(DW-1){1'b1}}};
        else if (shifted[ACC_W-1] && !(&shifted[ACC_W-2:DW-1]))
            res_c = {1'b1, {(DW-1){1'b0}}};
        else
            res_c = shifted[DW-1:0];
        if (RELU_EN && res_c[DW-1]) res_c = '0;
    end

    assign valid_out  = valid_q;
    assign data_out   = data_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_featuremap_conv2d_multich.sv
// Bench for featuremap_conv2d_multich: 2 channels, 4x4 output, ReLU and no-ReLU instances.
module tb_featuremap_conv2d_multich;
    localparam int unsigned DW = 16, CH = 2, W = 4, H = 4;
    localparam int PC = W + 2, NPIX = (W + 2) * (H + 2), NW = 9 * CH + 1;

    logic clk, rst, data_fifo_empty, cfg_load, w_wr;
    logic [DW*CH-1:0] data_in;
    logic [DW-1:0] w_data, data_out, data_nr;
    logic rdreq, rdreq_nr, cfg_busy, cfg_busy_nr, valid_out, valid_nr, frame_done, done_nr;

    featuremap_conv2d_multich #(.DATA_WIDTH(DW), .FRAC_BITS(8), .CHANNELS(CH), .WIDTH(W),
        .HEIGHT(H), .RELU_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_fifo_empty(data_fifo_empty),
        .rdreq(rdreq), .cfg_load(cfg_load), .w_wr(w_wr), .w_data(w_data),
        .cfg_busy(cfg_busy), .valid_out(valid_out), .data_out(data_out),
        .frame_done(frame_done));

    featuremap_conv2d_multich #(.DATA_WIDTH(DW), .FRAC_BITS(8), .CHANNELS(CH), .WIDTH(W),
        .HEIGHT(H), .RELU_EN(1'b0)) dut_nr (
        .clk(clk), .rst(rst), .data_in(data_in), .data_fifo_empty(data_fifo_empty),
        .rdreq(rdreq_nr), .cfg_load(cfg_load), .w_wr(w_wr), .w_data(w_data),
        .cfg_busy(cfg_busy_nr), .valid_out(valid_nr), .data_out(data_nr),
        .frame_done(done_nr));

    typedef struct {
        logic [15:0] d;
        logic        done;
        int          cyc;
    } obs_t;

    typedef struct {
        string              name;
        logic signed [15:0] w0, w1, bias, p0, p1;
        logic [15:0]        e_corner, e_edge, e_centre, e_nr;
    } vec_t;

    int   img [CH][NPIX];
    int   wt [NW];
    int   cyc, checks, errors, stray;
    int   save [16];
    obs_t oq [$];
    int   nq [$];
    int   cq [$];
    vec_t tbl [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out) oq.push_back('{d: data_out, done: frame_done, cyc: cyc});
        if (valid_nr) nq.push_back(int'(data_nr));
        if (frame_done && !valid_out) stray++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int od(input int i);
        return (i < oq.size()) ? int'(oq[i].d) : -1;
    endfunction
    function automatic int nd(input int i);
        return (i < nq.size()) ? nq[i] : -1;
    endfunction
    function automatic int odone(input int i);
        return (i < oq.size()) ? int'(oq[i].done) : -1;
    endfunction
    function automatic int lat(input int i);
        return (i < oq.size() && i < cq.size()) ? oq[i].cyc - cq[i] : -1;
    endfunction

    // Reference: direct 3x3xCH dot product on the padded image, Q-format requantisation
    function automatic int ref_px(input int y, input int x, input bit relu);
        longint acc = 0;
        for (int c = 0; c < int'(CH); c++)
            for (int ky = 0; ky < 3; ky++)
                for (int kx = 0; kx < 3; kx++)
                    acc += longint'(img[c][(y + ky) * PC + x + kx]) * longint'(wt[c*9 + ky*3 + kx]);
        acc = (acc + longint'(wt[NW-1]) * 256) >>> 8;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        if (relu && acc < 0) acc = 0;
        return int'(acc) & 'hFFFF;
    endfunction

    function automatic logic [DW*CH-1:0] pack(input int p);
        logic [15:0] a, b;
        a = 16'(img[0][p]);
        b = 16'(img[1][p]);
        return {a, b};
    endfunction

    function automatic bit interior(input int p);
        return (p / PC >= 1) && (p / PC <= H) && (p % PC >= 1) && (p % PC <= W);
    endfunction

    task automatic fill_uniform(input int v0, input int v1);
        for (int p = 0; p < NPIX; p++) begin
            img[0][p] = interior(p) ? v0 : 0;
            img[1][p] = interior(p) ? v1 : 0;
        end
    endtask

    task automatic fill_random();
        for (int p = 0; p < NPIX; p++)
            for (int c = 0; c < int'(CH); c++)
                img[c][p] = interior(p) ? int'($urandom_range(0, 2047)) - 1024 : 0;
    endtask

    task automatic rand_weights();
        for (int i = 0; i < NW - 1; i++) wt[i] = int'($urandom_range(0, 511)) - 256;
        wt[NW-1] = int'($urandom_range(0, 2047)) - 1024;
    endtask

    task automatic enter_load();
        @(negedge clk);
        data_fifo_empty = 1'b1;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        check("cfg_busy after boundary cfg_load", cfg_busy, 1);
    endtask

    task automatic load_weights();
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            w_wr = 1'b1;
            w_data = 16'(wt[i]);
            data_fifo_empty = 1'b0;
            #1;
            if (i == 9) check("rdreq low in LOAD", rdreq, 0);
        end
        @(negedge clk);
        w_wr = 1'b0;
        data_fifo_empty = 1'b1;
        check("cfg_busy low after bias word", cfg_busy, 0);
    endtask

    task automatic stream_frame(input int stall_pct, input int cfg_at, input int npix);
        int p = 0, guard = 0;
        bit cfg_done = 1'b0, cfg_pulsed = 1'b0;
        oq.delete(); nq.delete(); cq.delete();
        while (p < npix && guard < 2000) begin
            @(negedge clk);
            guard++;
            cfg_load = 1'b0;
            if (cfg_pulsed) begin
                check("cfg_load mid-frame ignored", cfg_busy, 0);
                cfg_pulsed = 1'b0;
            end
            data_fifo_empty = ($urandom_range(0, 99) < stall_pct);
            data_in = pack(p);
            if (p == cfg_at && !cfg_done) begin
                cfg_load = 1'b1;
                cfg_done = 1'b1;
                cfg_pulsed = 1'b1;
            end
            #1;
            if (rdreq) begin
                if (p / PC >= 2 && p % PC >= 2) cq.push_back(cyc);
                p++;
            end
        end
        if (p < npix) check("stream pixels consumed before timeout", p, npix);
        @(negedge clk);
        data_fifo_empty = 1'b1;
        cfg_load = 1'b0;
    endtask

    task automatic wait_outputs(input string name);
        int guard = 0;
        while (oq.size() < 16 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        check({name, " output count"}, oq.size(), 16);
        check({name, " no-relu output count"}, nq.size(), 16);
    endtask

    task automatic check_model(input string name);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s px%0d", name, i), od(i), ref_px(i / 4, i % 4, 1'b1));
            check($sformatf("%s nr px%0d", name, i), nd(i), ref_px(i / 4, i % 4, 1'b0));
            check($sformatf("%s frame_done%0d", name, i), odone(i), (i == 15) ? 1 : 0);
            check($sformatf("%s latency%0d", name, i), lat(i), 3);
        end
    endtask

    initial begin
        tbl[0] = '{name: "sum_all", w0: 16'h0100, w1: 16'h0100, bias: 16'h0200, p0: 16'h0100,
                   p1: 16'h0100, e_corner: 16'h0A00, e_edge: 16'h0E00, e_centre: 16'h1400,
                   e_nr: 16'h1400};
        tbl[1] = '{name: "sat_pos", w0: 16'h7FFF, w1: 16'h7FFF, bias: 16'h0000, p0: 16'h7FFF,
                   p1: 16'h7FFF, e_corner: 16'h7FFF, e_edge: 16'h7FFF, e_centre: 16'h7FFF,
                   e_nr: 16'h7FFF};
        tbl[2] = '{name: "neg_relu", w0: 16'h8001, w1: 16'h0000, bias: 16'h0000, p0: 16'h7FFF,
                   p1: 16'h7FFF, e_corner: 16'h0000, e_edge: 16'h0000, e_centre: 16'h0000,
                   e_nr: 16'h8000};
        tbl[3] = '{name: "mixed", w0: 16'h0080, w1: 16'hFF00, bias: 16'h0010, p0: 16'h0300,
                   p1: 16'h0100, e_corner: 16'h0210, e_edge: 16'h0310, e_centre: 16'h0490,
                   e_nr: 16'h0490};

        cyc = 0; checks = 0; errors = 0; stray = 0;
        rst = 1'b1; data_fifo_empty = 1'b0; cfg_load = 1'b0; w_wr = 1'b0;
        w_data = '0; data_in = '0;
        repeat (3) @(negedge clk);
        check("reset rdreq", rdreq, 0);
        check("reset valid_out", valid_out, 0);
        check("reset data_out", data_out, 0);
        check("reset frame_done", frame_done, 0);
        check("reset cfg_busy", cfg_busy, 1);
        rst = 1'b0;
        data_fifo_empty = 1'b1;

        // Centre tap pass-through: outputs equal the ch0 interior in raster order
        for (int i = 0; i < NW; i++) wt[i] = 0;
        wt[4] = 'h0100;
        load_weights();
        for (int p = 0; p < NPIX; p++) begin
            img[0][p] = interior(p) ? ((p / PC - 1) * W + (p % PC - 1) + 1) * 256 : 0;
            img[1][p] = 0;
        end
        stream_frame(0, -1, NPIX);
        wait_outputs("passthru");
        for (int i = 0; i < 16; i++)
            check($sformatf("passthru const px%0d", i), od(i), (i + 1) * 256);
        check_model("passthru");

        // Uniform-image vectors: corner/edge/centre constants plus full model compare
        foreach (tbl[t]) begin
            enter_load();
            for (int k = 0; k < 9; k++) begin
                wt[k] = tbl[t].w0;
                wt[9 + k] = tbl[t].w1;
            end
            wt[NW-1] = tbl[t].bias;
            load_weights();
            fill_uniform(tbl[t].p0, tbl[t].p1);
            stream_frame(0, -1, NPIX);
            wait_outputs(tbl[t].name);
            check({tbl[t].name, " corner"}, od(0), int'(tbl[t].e_corner));
            check({tbl[t].name, " edge"}, od(1), int'(tbl[t].e_edge));
            check({tbl[t].name, " centre"}, od(5), int'(tbl[t].e_centre));
            check({tbl[t].name, " nr centre"}, nd(5), int'(tbl[t].e_nr));
            check_model(tbl[t].name);
        end

        // Random frame unstalled, then the same frame with ~50% empty cycles
        enter_load();
        rand_weights();
        load_weights();
        @(negedge clk);
        w_wr = 1'b1;
        w_data = 16'h1234;
        @(negedge clk);
        w_wr = 1'b0;
        fill_random();
        stream_frame(0, -1, NPIX);
        wait_outputs("rand");
        check_model("rand");
        for (int i = 0; i < 16; i++) save[i] = od(i);
        stream_frame(50, -1, NPIX);
        wait_outputs("stall");
        for (int i = 0; i < 16; i++) check($sformatf("stall vs unstalled px%0d", i), od(i), save[i]);
        check_model("stall");

        // cfg_load mid-frame is ignored; at the boundary it reloads new weights
        fill_random();
        stream_frame(0, 10, NPIX);
        wait_outputs("cfg_mid");
        check_model("cfg_mid");
        enter_load();
        rand_weights();
        load_weights();
        fill_random();
        stream_frame(0, -1, NPIX);
        wait_outputs("reload");
        check_model("reload");

        // Reset while row 3 is streaming with outputs in flight
        fill_random();
        stream_frame(0, -1, 22);
        rst = 1'b1;
        @(negedge clk);
        check("mid-frame reset valid_out", valid_out, 0);
        check("mid-frame reset cfg_busy", cfg_busy, 1);
        check("mid-frame reset rdreq", rdreq, 0);
        rst = 1'b0;
        oq.delete(); nq.delete();
        repeat (6) @(negedge clk);
        check("no outputs after mid-frame reset", oq.size(), 0);
        rand_weights();
        load_weights();
        fill_random();
        stream_frame(0, -1, NPIX);
        wait_outputs("post_reset");
        check_model("post_reset");

        check("frame_done without valid_out", stray, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
